// File: rtl/alu_iter_pkg.sv
// -----------------------------------------------------------------------------
// alu_iter_pkg
// Shared definitions for the iterative ALU. It holds:
//   - the 3-bit operation codes, which keep the single-cycle ALU encoding;
//   - the sequencer state type.
// -----------------------------------------------------------------------------
package alu_iter_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_MULU = 3'b011;
  localparam logic [2:0] OP_DIVU = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage : alu_iter_pkg

// File: rtl/alu_comb.sv
// -----------------------------------------------------------------------------
// alu_comb
// Combinational single-cycle function unit. It provides AND, OR, XOR, ADD, SUB
// and SLT (signed), together with the overflow and carry flags. The iterative
// opcodes (MULU/DIVU) produce zero here; the sequencer in alu_iter handles them.
//
// Ports
//   a_i, b_i   in  WIDTH  operands
//   select_i   in  3      operation code
//   result_o   out WIDTH  result
//   v_o        out 1      signed overflow (ADD/SUB only)
//   carry_o    out 1      adder carry out (ADD/SUB only)
// -----------------------------------------------------------------------------
module alu_comb
  import alu_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       select_i,
  output logic [WIDTH-1:0] result_o,
  output logic             v_o,
  output logic             carry_o
);

  logic             subtract;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             add_ovf;

  // SUB and SLT share the adder as a + ~b + 1.
  assign subtract = (select_i == OP_SUB) || (select_i == OP_SLT);
  assign b_eff    = subtract ? ~b_i : b_i;
  assign sum      = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, subtract};

  // Signed overflow: both addends have the same sign, but the sum's sign differs.
  assign add_ovf  = (a_i[WIDTH-1] == b_eff[WIDTH-1]) &&
                    (sum[WIDTH-1] != a_i[WIDTH-1]);

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch inferred.
    result_o = '0;
    v_o      = 1'b0;
    carry_o  = 1'b0;
    case (select_i)
      OP_AND: result_o = a_i & b_i;
      OP_OR:  result_o = a_i | b_i;
      OP_XOR: result_o = a_i ^ b_i;
      OP_ADD, OP_SUB: begin
        result_o = sum[WIDTH-1:0];
        v_o      = add_ovf;
        carry_o  = sum[WIDTH];
      end
      // The difference's sign is flipped on overflow, so the signed compare
      // stays correct even when the subtraction wraps.
      OP_SLT: result_o = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
      default: ;
    endcase
  end

endmodule : alu_comb

// File: rtl/alu_iter.sv
// -----------------------------------------------------------------------------
// alu_iter
// Multi-cycle ALU for the execute stage.
//   - Single-cycle ops finish one cycle after start.
//   - MULU (shift-add) and DIVU (restoring) take one bit per cycle and finish
//     WIDTH+1 cycles after start.
//   - Results and flags are registered, and they hold until the next accepted
//     op completes.
//
// Configuration macro
//   ALU_ITER_DIV_EN  defined   : opcode 100 is DIVU, and the divider is built in.
//                    undefined : opcode 100 is reserved; it completes in one
//                                cycle with zero results, zero flags and err = 1.
//
// Ports
//   clk                in  1      rising-edge clock
//   reset              in  1      synchronous, active-high
//   start              in  1      request; accepted only while busy = 0
//   select             in  3      opcode, sampled with start
//   a, b               in  WIDTH  operands, sampled with start
//   result_lo          out WIDTH  result / product low half / quotient
//   result_hi          out WIDTH  product high half / remainder / 0
//   v, z, carry_out    out 1      overflow, zero, carry flags
//   err                out 1      reserved op or divide by zero
//   busy               out 1      iterative op in progress
//   done               out 1      one-cycle completion pulse
// -----------------------------------------------------------------------------
module alu_iter
  import alu_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       select,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             v,
  output logic             z,
  output logic             carry_out,
  output logic             err,
  output logic             busy,
  output logic             done
);

  localparam int             CW      = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_MAX = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // Iteration registers, shared by both iterative ops:
  //   MULU : work_hi = partial product, work_lo = multiplier,  opnd = multiplicand
  //   DIVU : work_hi = remainder,       work_lo = quotient,    opnd = divisor
  logic [WIDTH-1:0] work_hi_q, work_hi_d;
  logic [WIDTH-1:0] work_lo_q, work_lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;

  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic             v_q, v_d;
  logic             z_q, z_d;
  logic             c_q, c_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] comb_result;
  logic             comb_v;
  logic             comb_c;

  alu_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .a_i      (a),
    .b_i      (b),
    .select_i (select),
    .result_o (comb_result),
    .v_o      (comb_v),
    .carry_o  (comb_c)
  );

  // One shift-add step. The adder carry becomes the new top bit, and the
  // product's low half fills work_lo from the top as the multiplier shifts out.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nxt;
  logic [WIDTH-1:0] mul_lo_nxt;

  assign mul_sum    = {1'b0, work_hi_q} + {1'b0, (work_lo_q[0] ? opnd_q : {WIDTH{1'b0}})};
  assign mul_hi_nxt = mul_sum[WIDTH:1];
  assign mul_lo_nxt = {mul_sum[0], work_lo_q[WIDTH-1:1]};

`ifdef ALU_ITER_DIV_EN
  // One restoring step:
  //   - Shift the next dividend bit into the remainder.
  //   - Subtract the divisor when the remainder is at least the divisor.
  // A zero divisor always subtracts. That yields an all-ones quotient and
  // remainder = a, with no special case needed.
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] div_hi_nxt;
  logic [WIDTH-1:0] div_lo_nxt;

  assign div_shift  = {work_hi_q, work_lo_q[WIDTH-1]};
  assign div_ge     = div_shift >= {1'b0, opnd_q};
  assign div_diff   = div_shift[WIDTH-1:0] - opnd_q;
  assign div_hi_nxt = div_ge ? div_diff : div_shift[WIDTH-1:0];
  assign div_lo_nxt = {work_lo_q[WIDTH-2:0], div_ge};
`endif

  assign busy = (state_q == ST_MUL) || (state_q == ST_DIV);
  assign done = (state_q == ST_DONE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_hi_d = work_hi_q;
    work_lo_d = work_lo_q;
    opnd_d    = opnd_q;
    res_lo_d  = res_lo_q;
    res_hi_d  = res_hi_q;
    v_d       = v_q;
    z_d       = z_q;
    c_d       = c_q;
    err_d     = err_q;

    case (state_q)
      // busy is low in IDLE and DONE, so start is accepted here. That is what
      // makes back-to-back ops work from the DONE cycle.
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          case (select)
            OP_MULU: begin
              state_d   = ST_MUL;
              cnt_d     = CNT_MAX;
              work_hi_d = '0;
              work_lo_d = b;
              opnd_d    = a;
            end
`ifdef ALU_ITER_DIV_EN
            OP_DIVU: begin
              state_d   = ST_DIV;
              cnt_d     = CNT_MAX;
              work_hi_d = '0;
              work_lo_d = a;
              opnd_d    = b;
            end
`else
            OP_DIVU: begin
              state_d  = ST_DONE;
              res_lo_d = '0;
              res_hi_d = '0;
              v_d      = 1'b0;
              z_d      = 1'b0;
              c_d      = 1'b0;
              err_d    = 1'b1;
            end
`endif
            default: begin
              state_d  = ST_DONE;
              res_lo_d = comb_result;
              res_hi_d = '0;
              v_d      = comb_v;
              z_d      = (comb_result == '0);
              c_d      = comb_c;
              err_d    = 1'b0;
            end
          endcase
        end
      end

      ST_MUL: begin
        work_hi_d = mul_hi_nxt;
        work_lo_d = mul_lo_nxt;
        if (cnt_q == '0) begin
          state_d  = ST_DONE;
          res_lo_d = mul_lo_nxt;
          res_hi_d = mul_hi_nxt;
          v_d      = (mul_hi_nxt != '0);
          z_d      = (mul_hi_nxt == '0) && (mul_lo_nxt == '0);
          c_d      = 1'b0;
          err_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

`ifdef ALU_ITER_DIV_EN
      ST_DIV: begin
        work_hi_d = div_hi_nxt;
        work_lo_d = div_lo_nxt;
        if (cnt_q == '0) begin
          state_d  = ST_DONE;
          res_lo_d = div_lo_nxt;
          res_hi_d = div_hi_nxt;
          v_d      = 1'b0;
          z_d      = (div_hi_nxt == '0) && (div_lo_nxt == '0);
          c_d      = 1'b0;
          err_d    = (opnd_q == '0);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the work registers are cleared along with the control and output
      // state, so the DUT has no X-dependent history after reset.
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      work_hi_q <= '0;
      work_lo_q <= '0;
      opnd_q    <= '0;
      res_lo_q  <= '0;
      res_hi_q  <= '0;
      v_q       <= 1'b0;
      z_q       <= 1'b0;
      c_q       <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_hi_q <= work_hi_d;
      work_lo_q <= work_lo_d;
      opnd_q    <= opnd_d;
      res_lo_q  <= res_lo_d;
      res_hi_q  <= res_hi_d;
      v_q       <= v_d;
      z_q       <= z_d;
      c_q       <= c_d;
      err_q     <= err_d;
    end
  end

  assign result_lo = res_lo_q;
  assign result_hi = res_hi_q;
  assign v         = v_q;
  assign z         = z_q;
  assign carry_out = c_q;
  assign err       = err_q;

endmodule : alu_iter

// File: tb/tb_alu_iter.sv
// -----------------------------------------------------------------------------
// tb_alu_iter
// Self-checking bench for alu_iter at WIDTH = 32. A transaction-level model
// computes each op's results with plain arithmetic and predicts busy/done from
// the accept edge and the latency. One compare process checks the DUT against
// that model on every cycle. DIVU expectations follow ALU_ITER_DIV_EN.
// -----------------------------------------------------------------------------
module tb_alu_iter;
  import alu_iter_pkg::*;

  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   sel;
  logic [W-1:0] a_in, b_in;
  logic [W-1:0] res_lo, res_hi;
  logic         v_f, z_f, c_f, err_f, busy_f, done_f;

  always #5 clk = ~clk;

  alu_iter #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .select    (sel),
    .a         (a_in),
    .b         (b_in),
    .result_lo (res_lo),
    .result_hi (res_hi),
    .v         (v_f),
    .z         (z_f),
    .carry_out (c_f),
    .err       (err_f),
    .busy      (busy_f),
    .done      (done_f)
  );

  typedef struct packed {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         v;
    logic         z;
    logic         c;
    logic         err;
  } res_t;

  typedef struct packed {
    res_t        cur;
    res_t        pend;
    logic        pend_v;
    logic [31:0] done_edge;
    logic        busy;
    logic        done;
  } mdl_t;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference arithmetic, taken straight from the operation definitions.
  function automatic res_t model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    res_t         r;
    longint       sx, sy, s;
    logic [W:0]   u;
    logic [2*W-1:0] p;
    r  = '0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (op)
      OP_AND: r.lo = x & y;
      OP_OR:  r.lo = x | y;
      OP_XOR: r.lo = x ^ y;
      OP_ADD: begin
        u = {1'b0, x} + {1'b0, y};
        r.lo = u[W-1:0]; r.c = u[W];
        s = sx + sy; r.v = (s > SMAX) || (s < SMIN);
      end
      OP_SUB: begin
        u = {1'b0, x} + {1'b0, ~y} + 33'd1;
        r.lo = u[W-1:0]; r.c = u[W];
        s = sx - sy; r.v = (s > SMAX) || (s < SMIN);
      end
      OP_SLT: r.lo = (sx < sy) ? 32'd1 : 32'd0;
      OP_MULU: begin
        p = {32'b0, x} * {32'b0, y};
        r.lo = p[W-1:0]; r.hi = p[2*W-1:W]; r.v = (r.hi != 0);
      end
      default: begin
`ifdef ALU_ITER_DIV_EN
        if (y == 0) begin r.lo = '1; r.hi = x; r.err = 1'b1; end
        else begin r.lo = x / y; r.hi = x % y; end
`else
        r.err = 1'b1;
        return r;
`endif
      end
    endcase
    r.z = (r.lo == 0) && (r.hi == 0);
    return r;
  endfunction

  function automatic logic is_iter(input logic [2:0] op);
`ifdef ALU_ITER_DIV_EN
    return (op == OP_MULU) || (op == OP_DIVU);
`else
    return (op == OP_MULU);
`endif
  endfunction

  // Advances the model by one clock edge n. An accepted op is visible after
  // edge done_edge: the accept edge itself for single-cycle ops, or W edges
  // later for iterative ops. Between those two edges the op is busy.
  function automatic mdl_t step(input mdl_t m, input logic [31:0] n, input logic rst,
                                input logic st, input logic [2:0] op,
                                input logic [W-1:0] x, input logic [W-1:0] y);
    mdl_t r;
    r = m;
    if (rst) begin
      r = '0;
    end else begin
      if (st && !m.busy) begin
        r.pend      = model(op, x, y);
        r.pend_v    = 1'b1;
        r.done_edge = is_iter(op) ? n + W : n;
      end
      r.done = r.pend_v && (n == r.done_edge);
      if (r.done) r.cur = r.pend;
      r.busy = r.pend_v && (n < r.done_edge);
    end
    return r;
  endfunction

  mdl_t        mdl    = '0;
  logic [31:0] edge_n = '0;

  always @(posedge clk) begin
    mdl    <= step(mdl, edge_n + 32'd1, reset, start, sel, a_in, b_in);
    edge_n <= edge_n + 32'd1;
  end

  function automatic res_t dut_res();
    return {res_lo, res_hi, v_f, z_f, c_f, err_f};
  endfunction

  always @(negedge clk) begin
    if (chk_en)
      check("cycle", {58'b0, busy_f, done_f, dut_res()}, {58'b0, mdl.busy, mdl.done, mdl.cur});
  end

  // Starts an op at the current negedge and scrambles the inputs after the
  // accept edge. It then waits, with a bound, for done. When poke > 0 it
  // raises start again in cycle k+poke, while the op should still be busy.
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       input int poke, output int lat, output int busy_cyc);
    start = 1'b1; sel = op; a_in = x; b_in = y;
    @(posedge clk); #1;
    start = 1'b0; sel = 3'($urandom); a_in = $urandom; b_in = $urandom;
    lat = 0; busy_cyc = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy_f) busy_cyc++;
      if (lat == poke) begin start = 1'b1; sel = OP_ADD; end
      else start = 1'b0;
    end while (!done_f && lat < 60);
    start = 1'b0;
    if (!done_f) check("done_timeout", {127'b0, done_f}, 128'd1);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int   lat, bc, cnt;
    res_t r;

    reset = 1'b1; start = 1'b0; sel = '0; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("reset_state", {60'b0, busy_f, done_f, dut_res()}, 128'd0);
    reset = 1'b0;

    // Hand-computed anchors for the model itself.
    r = model(OP_ADD, 32'h7FFF_FFFF, 32'h1);
    check("pin_add", r, {32'h8000_0000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0});
    r = model(OP_SUB, 32'h1, 32'h2);
    check("pin_sub", r, {32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0});
    r = model(OP_SLT, 32'h7557_F555, 32'hD7DA_FAAA);
    check("pin_slt", r, {32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0});
    r = model(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("pin_mul", r, {32'h1, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b0});

    @(negedge clk);
    do_op(OP_ADD, 32'h7FFF_FFFF, 32'h1, 0, lat, bc);
    check("add_lat", lat, 1);
    check("add_busy", bc, 0);
    check("add_res", dut_res(), {32'h8000_0000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0});

    do_op(OP_SUB, 32'h1, 32'h2, 0, lat, bc);
    check("sub_res", dut_res(), {32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0});

    do_op(OP_SLT, 32'h7557_F555, 32'hD7DA_FAAA, 0, lat, bc);
    check("slt_res", dut_res(), {32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0});

    do_op(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, lat, bc);
    check("mul_lat", lat, 33);
    check("mul_busy", bc, 32);
    check("mul_res", dut_res(), {32'h1, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b0});

`ifdef ALU_ITER_DIV_EN
    do_op(OP_DIVU, 32'd100, 32'd7, 0, lat, bc);
    check("div_lat", lat, 33);
    check("div_res", dut_res(), {32'd14, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0});
    do_op(OP_DIVU, 32'd5, 32'd0, 0, lat, bc);
    check("div0_lat", lat, 33);
    check("div0_res", dut_res(), {32'hFFFF_FFFF, 32'd5, 1'b0, 1'b0, 1'b0, 1'b1});
`else
    do_op(OP_DIVU, 32'd100, 32'd7, 0, lat, bc);
    check("rsv_lat", lat, 1);
    check("rsv_res", dut_res(), {32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1});
`endif

    // Reset in cycle k+10 of a MULU aborts it.
    start = 1'b1; sel = OP_MULU; a_in = 32'h1234_5678; b_in = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid", {60'b0, busy_f, done_f, dut_res()}, 128'd0);
    reset = 1'b0;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_f) cnt++;
    end
    check("rst_no_done", cnt, 0);

    // Back-to-back: an ADD issued in the MULU's done cycle.
    do_op(OP_MULU, 32'd3, 32'd5, 0, lat, bc);
    check("b2b_mul", dut_res(), {32'd15, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    do_op(OP_ADD, 32'hFFFF_FFFF, 32'h1, 0, lat, bc);
    check("b2b_lat", lat, 1);
    check("b2b_add", dut_res(), {32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0});

    // Random traffic, including starts while busy and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 2) == 0);
      sel   = 3'($urandom);
      a_in  = pick();
      b_in  = pick();
      reset = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    start = 1'b0; reset = 1'b0;
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_alu_iter

// File: doc/alu_iter.md
# alu_iter

Parametrised multi-cycle ALU: the successor of the single-cycle 32-bit datapath ALU. It keeps the existing single-cycle operation codes and flag semantics, and adds iterative unsigned multiply and divide behind a start/busy/done handshake. It sits in the execute stage of the multi-cycle MIPS datapath, where the control FSM waits on `done`.

## Interface
**Parameters**
- `WIDTH`, 32: operand and result width, ≥ 4.

**Ports**
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: request. Accepted only when `busy` = 0.
- `select`, in, 3: operation code, sampled with `start`.
- `a`, `b`, in, WIDTH: operands, sampled with `start`.
- `result_lo`, out, WIDTH: main result. For MULU it holds the product's low half; for DIVU, the quotient.
- `result_hi`, out, WIDTH: MULU product high half, or DIVU remainder. 0 for single-cycle ops.
- `v`, `z`, `carry_out`, out, 1: overflow, zero and carry flags. Registered together with the result.
- `err`, out, 1: reserved op, or divide by zero. Valid with `done`.
- `busy`, out, 1: an iterative op is in progress.
- `done`, out, 1: one-cycle pulse; the result is valid from this cycle on.

## Operation
- **Opcodes:** 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed), 101 XOR, 011 MULU, 100 DIVU.
- **ADD/SUB:** SUB computes a + ~b + 1.
  - `carry_out` is the carry out of the WIDTH-bit adder.
  - `v` is the signed overflow.
- **SLT:** result_lo = 1 if a < b (signed), else 0. SLT uses the sign of the difference XOR overflow.
- **Flags for logic ops and SLT:** `v` = 0, `carry_out` = 0.
- **`z`:** 1 iff the whole visible result is zero. For MULU and DIVU this covers both `result_lo` and `result_hi`.
- **MULU:** unsigned shift-add, one bit per cycle, 2·WIDTH-bit product.
  - `v` = 1 iff the high half is non-zero.
  - `carry_out` = 0.
- **DIVU:** unsigned restoring division, one bit per cycle.
  - b = 0 gives quotient all-ones, remainder = a, `err` = 1, with the same latency.
- **FSM states:**
  - IDLE: accepted single-cycle op → DONE; MULU → MUL; DIVU → DIV.
  - MUL/DIV: iteration counter runs from WIDTH−1 down to 0; → DONE when it reaches 0.
  - DONE: → IDLE, or directly into a new op if `start` is accepted in this cycle.
- **Holding:** outputs hold their last value until the next accepted `start` completes. No output changes while IDLE.

## Timing
- **Reset:** all outputs 0, state IDLE, counter 0.
- **Reset mid-operation:** aborts the op. `busy` = 0 and `done` = 0 in the next cycle, and the results clear.
- **Single-cycle ops:** `start` is sampled at edge k. `done` and the result appear in cycle k+1. `busy` stays 0.
- **MULU/DIVU:** `start` is sampled at edge k.
  - `busy` is high in cycles k+1 … k+WIDTH.
  - `done` is high in cycle k+WIDTH+1, with `busy` = 0.
  - Latency is exactly WIDTH+1 cycles, independent of the data.
- **`start` while `busy`:** ignored completely; operands are not resampled.
- **`start` during the `done` cycle:** accepted, giving back-to-back ops.
- **Operand stability:** `a`, `b` and `select` may change freely after the accepting edge.

## Configuration
- **`ALU_ITER_DIV_EN` defined:** opcode 100 is DIVU, as described above, and the divider datapath is compiled in.
- **Not defined:** opcode 100 is reserved.
  - `done` in cycle k+1, results 0, flags 0, `err` = 1.
  - No divider logic is synthesised.
- **MULU:** always present.

## Structure
- **Package `alu_iter_pkg`:**
  - Opcode localparams: OP_AND, OP_OR, OP_ADD, OP_MULU, OP_DIVU, OP_XOR, OP_SUB, OP_SLT.
  - State enum: ST_IDLE, ST_MUL, ST_DIV, ST_DONE.
- **Sub-module `alu_comb`:** combinational single-cycle function unit (logic ops, adder, SLT, flags), parametrised by WIDTH.
- **`alu_iter`:** instantiates `alu_comb` and contains the FSM, counter, shift registers and output registers.

## Test plan
All scenarios use WIDTH = 32.
1. **ADD overflow:** ADD a=0x7FFFFFFF, b=0x00000001 → result_lo 0x80000000, v=1, carry_out=0, z=0, `done` at k+1, `busy` never high.
2. **SUB and SLT:**
   - SUB a=1, b=2 → 0xFFFFFFFF, carry_out=0, v=0.
   - SLT a=0x7557F555, b=0xD7DAFAAA → result_lo 0, z=1.
3. **MULU:**
   - a=b=0xFFFFFFFF → hi 0xFFFFFFFE, lo 0x00000001, v=1; `busy` for exactly 32 cycles; `done` at k+33.
   - A second `start` issued at k+5 is ignored.
4. **DIVU (macro defined):**
   - 100 / 7 → lo 14, hi 2, err=0 at k+33.
   - 5 / 0 → lo 0xFFFFFFFF, hi 5, err=1.
5. **DIVU (macro undefined):** op 100 → `done` at k+1, err=1, results 0.
6. **Reset and back-to-back:**
   - `reset` asserted at cycle k+10 of a MULU → `busy` = 0 and outputs 0 at k+11; no `done` pulse.
   - ADD started in the `done` cycle of a MULU → its `done` follows one cycle later.
